// File: rtl/tx_lane_pkg.sv
// Shared constants and state encoding for the PCIe Tx lane symbol schedulers.
package tx_lane_pkg;

    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] D_IDLE = 8'h00;

    localparam int unsigned SYM_BITS = 10;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_PKT,
        ST_SKP
    } lane_state_e;

endpackage

// File: rtl/tx_lane_sched_skp_timer.sv
// SKP interval counter with sticky pending flag; one tick per emitted symbol.
module skp_timer #(
    parameter int unsigned INTERVAL = 1180
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clr,
    output logic pend
);

    localparam int unsigned CW = $clog2(INTERVAL);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;

    // A clear coinciding with a tick counts that symbol as the first of the new interval.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (clr) begin
            pend_d = 1'b0;
            cnt_d  = tick ? CW'(1) : '0;
        end else if (tick) begin
            if (cnt_q == CW'(INTERVAL - 1)) begin
                cnt_d  = '0;
                pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/tx_lane_sched.sv
// Per-lane Tx symbol scheduler: picks packet data, SKP ordered sets or logical
// idle once per 10-bit symbol slot and frames it for the encoder/serialiser.
module tx_lane_sched
    import tx_lane_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_LEN      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lane_en,
    input  logic       tx_valid,
    input  logic       tx_k,
    input  logic [7:0] tx_byte,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       sym_k,
    output logic [7:0] sym_byte,
    output logic       sym_strobe,
    output logic       ser_en,
    output logic       skp_sent,
    output logic       tx_abort
);

    lane_state_e state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  skp_idx_q, skp_idx_d;
    logic        sym_k_q, sym_k_d;
    logic [7:0]  sym_byte_q, sym_byte_d;
    logic        sym_strobe_q, sym_strobe_d;
    logic        skp_sent_q, skp_sent_d;

    logic boundary;
    logic accept;
    logic com_issue;
    logic skp_pend;
    logic timer_tick;
    logic timer_clr;

    // Leaving OFF is itself a boundary so the first symbol goes out one cycle after enable.
    assign boundary = (state_q == ST_OFF) ? lane_en
                                          : (bit_cnt_q == 4'(SYM_BITS - 1));

    assign tx_ready = boundary & lane_en &
                      (((state_q == ST_IDLE) & ~skp_pend) | (state_q == ST_PKT));
    assign accept   = tx_valid & tx_ready;
    assign tx_abort = boundary & ~lane_en & (state_q == ST_PKT);
    assign ser_en   = (state_q != ST_OFF);

    assign timer_tick = boundary & lane_en;
    assign timer_clr  = boundary & (~lane_en | com_issue);

    skp_timer #(
        .INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (timer_tick),
        .clr  (timer_clr),
        .pend (skp_pend)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = '0;
        skp_idx_d    = skp_idx_q;
        sym_k_d      = sym_k_q;
        sym_byte_d   = sym_byte_q;
        sym_strobe_d = 1'b0;
        skp_sent_d   = 1'b0;
        com_issue    = 1'b0;

        if (ser_en && bit_cnt_q != 4'(SYM_BITS - 1)) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        if (boundary) begin
            if (!lane_en) begin
                state_d = ST_OFF;
            end else begin
                sym_strobe_d = 1'b1;
                sym_k_d      = 1'b0;
                sym_byte_d   = D_IDLE;
                case (state_q)
                    ST_OFF: begin
                        state_d = ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (skp_pend) begin
                            com_issue  = 1'b1;
                            sym_k_d    = 1'b1;
                            sym_byte_d = K_COM;
                            skp_idx_d  = 3'd1;
                            state_d    = ST_SKP;
                        end else if (accept) begin
                            sym_k_d    = tx_k;
                            sym_byte_d = tx_byte;
                            state_d    = tx_last ? ST_IDLE : ST_PKT;
                        end
                    end
                    ST_PKT: begin
                        // Without valid data the slot carries idle (underrun).
                        if (accept) begin
                            sym_k_d    = tx_k;
                            sym_byte_d = tx_byte;
                            if (tx_last) begin
                                state_d   = skp_pend ? ST_SKP : ST_IDLE;
                                skp_idx_d = '0;
                            end
                        end
                    end
                    ST_SKP: begin
                        sym_k_d = 1'b1;
                        if (skp_idx_q == '0) begin
                            com_issue  = 1'b1;
                            sym_byte_d = K_COM;
                            skp_idx_d  = 3'd1;
                        end else begin
                            sym_byte_d = K_SKP;
                            if (skp_idx_q == 3'(SKP_LEN)) begin
                                skp_sent_d = 1'b1;
                                state_d    = ST_IDLE;
                            end else begin
                                skp_idx_d = skp_idx_q + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_OFF;
            bit_cnt_q    <= '0;
            skp_idx_q    <= '0;
            sym_k_q      <= 1'b0;
            sym_byte_q   <= '0;
            sym_strobe_q <= 1'b0;
            skp_sent_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            skp_idx_q    <= skp_idx_d;
            sym_k_q      <= sym_k_d;
            sym_byte_q   <= sym_byte_d;
            sym_strobe_q <= sym_strobe_d;
            skp_sent_q   <= skp_sent_d;
        end
    end

    assign sym_k      = sym_k_q;
    assign sym_byte   = sym_byte_q;
    assign sym_strobe = sym_strobe_q;
    assign skp_sent   = skp_sent_q;

endmodule

// File: doc/tx_lane_sched.md
Name: tx_lane_sched

Overview:
- Symbol scheduler for one PCIe Tx lane, running on the bit clock.
- Sits upstream of the 8b/10b encoder and the lane serialiser.
- Every 10 clocks it selects one symbol (K flag + byte) from three sources:
  - packet data from the link layer (valid/ready),
  - periodic SKP ordered sets,
  - logical idle.
- Drives the serialiser enable and a symbol-frame strobe so that encoder output and serialiser bit index stay aligned.

Parameters:
- SKP_INTERVAL, 1180, symbols between SKP ordered-set starts (min 8).
- SKP_LEN, 3, SKP symbols following COM in one SKP ordered set (1..4).

Ports:
- clk  in  1  bit clock
- rst  in  1  asynchronous, active-low reset
- lane_en  in  1  lane transmit enable from LTSSM
- tx_valid  in  1  link-layer symbol valid
- tx_k  in  1  link-layer symbol is K-code
- tx_byte  in  8  link-layer symbol byte
- tx_last  in  1  last symbol of packet
- tx_ready  out  1  symbol accepted this cycle when tx_valid & tx_ready
- sym_k  out  1  scheduled symbol K flag, to encoder
- sym_byte  out  8  scheduled symbol byte, to encoder
- sym_strobe  out  1  one-cycle pulse: new symbol on sym_k/sym_byte
- ser_en  out  1  serialiser enable
- skp_sent  out  1  one-cycle pulse when last SKP of a set is issued
- tx_abort  out  1  one-cycle pulse: packet cut by lane_en drop

Behaviour:
- Reset values: all outputs 0, state OFF, bit_cnt 0, skp_timer 0, skp_pend 0.
- bit_cnt counts 0..9 while ser_en=1 and wraps 9→0. Boundary = cycle with bit_cnt==9, or the first cycle of a start from OFF.
- All symbol decisions are taken at the boundary. sym_* are registered, update in the cycle after the boundary, and hold for 10 clocks. sym_strobe pulses in that same cycle.
- States:
  - OFF: ser_en=0. lane_en=1 → IDLE. The first symbol issues next cycle and bit_cnt restarts at 0.
  - IDLE: emits logical idle (K=0, 8'h00).
  - PKT: emits accepted data symbols.
  - SKP: emits COM (K=1, 8'hBC), then SKP_LEN × SKP (K=1, 8'h1C). A sub-counter tracks position.
- Priority at a boundary in IDLE: skp_pend > tx_valid > idle.
  - SKP wins a tie with tx_valid. tx_ready stays low and data waits.
- tx_ready = boundary & lane_en & (state IDLE & !skp_pend, or state PKT). It is combinational.
- PKT: each accepted symbol is emitted.
  - tx_valid=0 at a PKT boundary → emit idle, stay PKT (underrun). This is legal but not desired.
  - Accepted tx_last → IDLE, or SKP if skp_pend.
  - SKP is never inserted mid-packet.
- skp_timer increments once per emitted symbol (every boundary, any state except OFF).
  - At SKP_INTERVAL-1: set skp_pend (sticky) and wrap to 0.
  - skp_pend and the timer clear on the boundary issuing COM.
  - The timer resumes counting from that symbol.
- SKP: a set is never interrupted by data. After the last SKP, skp_sent pulses and the state goes to IDLE.
- lane_en=0 is sampled at a boundary. At that boundary:
  - state goes to OFF, ser_en drops the following cycle;
  - skp_pend and the timer clear;
  - if in PKT, tx_abort pulses.
  - A partial SKP set is abandoned.
- Async reset mid-symbol: immediate return to reset values. No partial symbol is flagged.
- tx_ready=0 whenever lane_en=0 or state OFF.

Decomposition:
- Shared package tx_lane_pkg holds:
  - K_COM=8'hBC, K_SKP=8'h1C, D_IDLE=8'h00;
  - SYM_BITS=10;
  - the state enum (OFF, IDLE, PKT, SKP).
- Sub-module skp_timer: counter plus sticky pending flag, with clear input. It is reusable by the other lanes' schedulers.
- Everything else lives in one module.

Test Plan:
- Reset, lane_en=1, no traffic:
  - sym_strobe every 10 clocks;
  - sym=(0,00) repeated;
  - first strobe the cycle after enable;
  - ser_en=1.
- SKP_INTERVAL=16, SKP_LEN=3, idle only:
  - every 16th symbol slot begins BC(K), 1C(K), 1C(K), 1C(K);
  - skp_sent on the 1C(K) slot;
  - COM start spacing 160 clocks.
- 5-symbol packet (FB, 3 data, FD-K with tx_last), tx_valid held:
  - one symbol accepted per boundary;
  - output order matches;
  - tx_ready high exactly 5 cycles.
- skp_pend rising mid-packet (SKP_INTERVAL=16, 20-symbol packet):
  - SKP set starts on the slot right after the tx_last symbol, not before.
- skp_pend and tx_valid together in IDLE:
  - COM emitted first;
  - tx_ready low for 4 boundaries;
  - data follows the set.
- lane_en dropped during packet symbol 3:
  - tx_abort pulse at next boundary;
  - ser_en low one cycle later;
  - re-enable restarts with idle and skp_timer=0.
